// File: rtl/scan_cfg_pkg.sv
// ============================================================================
//  Module      : scan_cfg_pkg
//  Description : Shared FSM encoding and sizing helpers for the scan loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_cfg_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Bits carried by the final host word; zero means the last word is full.
    function automatic int calc_rem(input int chain_len, input int word_w);
        return chain_len % word_w;
    endfunction

    function automatic int calc_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Width of a counter that must represent 0..max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_capture.sv
// ============================================================================
//  Module      : scan_capture
//  Description : Deserializes scan_out into readback words, left-aligning a
//                short final word when flushed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_capture
    import scan_cfg_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic              cap_bit,
    input  logic              flush,
    input  logic              clear,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int                c_cnt_w = cnt_width(WORD_W);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(WORD_W);

    logic [WORD_W-1:0]  r_sr;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WORD_W-1:0]  r_rb_data;
    logic               r_rb_valid;

    logic [WORD_W-1:0]  w_sr_next;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic [c_cnt_w-1:0] w_pad;
    logic               w_emit;

    always_comb begin
        w_sr_next  = {r_sr[WORD_W-2:0], cap_bit};
        w_cnt_next = r_cnt + c_cnt_w'(1);
        w_pad      = c_full - w_cnt_next;
        w_emit     = (w_cnt_next == c_full) || flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (clear) begin
                r_sr  <= '0;
                r_cnt <= '0;
            end else if (cap_en) begin
                if (w_emit) begin
                    // A short final word is padded with zeros in its low bits.
                    r_rb_data  <= w_sr_next << w_pad;
                    r_rb_valid <= 1'b1;
                    r_sr       <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_sr  <= w_sr_next;
                    r_cnt <= w_cnt_next;
                end
            end
        end
    end

    assign rb_data  = r_rb_data;
    assign rb_valid = r_rb_valid;

endmodule

`default_nettype wire

// File: rtl/scan_cfg_loader.sv
// ============================================================================
//  Module      : scan_cfg_loader
//  Description : Streams host configuration words into the scan chain while
//                returning the chain's previous contents as readback words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_cfg_loader
    import scan_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              scan_clk,
    input  logic              scan_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              scan_in,
    output logic              scan_en,
    input  logic              scan_out,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int c_tot_w = cnt_width(CHAIN_LEN);
    localparam int c_bit_w = cnt_width(WORD_W);
    localparam int c_sum_w = ((c_tot_w > c_bit_w) ? c_tot_w : c_bit_w) + 1;
    localparam int c_rem   = calc_rem(CHAIN_LEN, WORD_W);

    localparam logic [c_sum_w-1:0] c_chain_len = c_sum_w'(CHAIN_LEN);
    localparam logic [c_sum_w-1:0] c_word_len  = c_sum_w'(WORD_W);
    localparam logic [c_tot_w-1:0] c_tot_max   = c_tot_w'(CHAIN_LEN);
    localparam logic [c_bit_w-1:0] c_full_cnt  = c_bit_w'(WORD_W);
    localparam logic [c_bit_w-1:0] c_tail_cnt  = c_bit_w'(c_rem);

    logic [1:0]         r_state;
    logic [WORD_W-1:0]  r_buf;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic [c_tot_w-1:0] r_total;
    logic               r_scan_en;
    logic               r_scan_in;

    logic               w_in_load;
    logic [c_sum_w-1:0] w_committed;
    logic               w_issue;
    logic               w_buf_free;
    logic               w_room;
    logic               w_xfer;
    logic               w_last_word;
    logic [c_bit_w-1:0] w_load_cnt;
    logic               w_last_capture;
    logic               w_cap_clear;

    always_comb begin
        w_in_load      = (r_state == c_st_load);
        // Bits already shifted plus bits still waiting in the buffer.
        w_committed    = c_sum_w'(r_total) + c_sum_w'(r_bit_cnt);
        w_issue        = w_in_load && (r_bit_cnt != '0) && (r_total != c_tot_max);
        w_buf_free     = (r_bit_cnt <= c_bit_w'(1));
        w_room         = (w_committed < c_chain_len);
        w_xfer         = word_valid && word_ready;
        w_last_word    = ((w_committed + c_word_len) > c_chain_len);
        w_load_cnt     = w_last_word ? c_tail_cnt : c_full_cnt;
        w_last_capture = w_in_load && r_scan_en && (r_total == c_tot_max);
        w_cap_clear    = w_in_load && abort;
    end

    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            r_state   <= c_st_idle;
            r_buf     <= '0;
            r_bit_cnt <= '0;
            r_total   <= '0;
            r_scan_en <= 1'b0;
            r_scan_in <= 1'b0;
        end else begin
            r_scan_en <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start && !abort) begin
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
                    if (abort) begin
                        r_state   <= c_st_idle;
                        r_buf     <= '0;
                        r_bit_cnt <= '0;
                        r_total   <= '0;
                    end else if (r_total == c_tot_max) begin
                        // Final bit is on the chain this cycle; finish next.
                        r_state   <= c_st_done;
                        r_total   <= '0;
                    end else begin
                        if (w_issue) begin
                            r_scan_en <= 1'b1;
                            r_scan_in <= r_buf[WORD_W-1];
                            r_buf     <= {r_buf[WORD_W-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - c_bit_w'(1);
                            r_total   <= r_total + c_tot_w'(1);
                        end
                        if (w_xfer) begin
                            r_buf     <= word_data;
                            r_bit_cnt <= w_load_cnt;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    scan_capture #(
        .WORD_W (WORD_W)
    ) u_capture (
        .clk      (scan_clk),
        .rst      (scan_rst),
        .cap_en   (r_scan_en),
        .cap_bit  (scan_out),
        .flush    (w_last_capture),
        .clear    (w_cap_clear),
        .rb_data  (rb_data),
        .rb_valid (rb_valid)
    );

    assign word_ready = w_in_load && w_buf_free && w_room;
    assign scan_en    = r_scan_en;
    assign scan_in    = r_scan_in;
    assign busy       = w_in_load;
    assign done       = (r_state == c_st_done);

endmodule

`default_nettype wire

// File: tb/tb_scan_cfg_loader.sv
// ============================================================================
//  Module      : tb_scan_cfg_loader
//  Description : Self-checking bench for scan_cfg_loader on a 12-bit chain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_cfg_loader;

    logic        scan_clk = 1'b0;
    logic        scan_rst, start, abort, word_valid, word_ready;
    logic        scan_in, scan_en, scan_out, rb_valid, busy, done;
    logic [7:0]  word_data, rb_data;
    logic [11:0] chain, preload_val;
    logic        preload_en;

    int total_cnt = 0;
    int bad_cnt   = 0;

    int          o_en, o_first, o_last, o_done_n, o_done_cyc;
    int          o_en_after_ev, o_rb_after_ev, o_busy_after_done;
    logic        o_busy1, o_ready1, o_done_busy;
    logic [12:0] o_post;
    logic [7:0]  o_rb[$];
    int          o_rb_cyc[$];

    always #5 scan_clk = ~scan_clk;

    // Chain of shift_reg cells: first bit sent ends up in the MSB.
    assign scan_out = chain[11];
    always @(posedge scan_clk) begin
        if (preload_en)   chain <= preload_val;
        else if (scan_en) chain <= {chain[10:0], scan_in};
    end

    scan_cfg_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut (
        .scan_clk   (scan_clk),
        .scan_rst   (scan_rst),
        .start      (start),
        .abort      (abort),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .scan_in    (scan_in),
        .scan_en    (scan_en),
        .scan_out   (scan_out),
        .rb_data    (rb_data),
        .rb_valid   (rb_valid),
        .busy       (busy),
        .done       (done)
    );

    // Reference: a complete load leaves the first 12 stream bits in the chain.
    function automatic logic [11:0] ref_chain(input logic [7:0] w0, input logic [7:0] w1);
        logic [15:0] s;
        s = {w0, w1};
        return s[15:4];
    endfunction

    function automatic logic [7:0] ref_rb(input logic [11:0] old, input int k);
        logic [15:0] s;
        s = {old, 4'h0};
        return (k == 0) ? s[15:8] : s[7:0];
    endfunction

    task automatic load_chain(input logic [11:0] v);
        @(negedge scan_clk);
        preload_val = v;
        preload_en  = 1'b1;
        @(negedge scan_clk);
        preload_en  = 1'b0;
    endtask

    // Drives one load and records what the DUT does; checking is done by callers.
    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input int gap_len,
                            input int abort_at, input int rst_at, input int start_at,
                            input bit start_in_done);
        logic [7:0] words [2];
        int  idx, gap, tail, post_cyc;
        bit  ev, st_done;
        words[0] = w0;
        words[1] = w1;
        o_en = 0; o_first = -1; o_last = -1; o_done_n = 0; o_done_cyc = -1;
        o_en_after_ev = 0; o_rb_after_ev = 0; o_busy_after_done = 0;
        o_done_busy = 1'b1; o_post = '1;
        o_rb.delete(); o_rb_cyc.delete();
        idx = 0; gap = gap_len; tail = -1; post_cyc = -1; ev = 0; st_done = 0;
        @(negedge scan_clk);
        start = 1'b1;
        @(negedge scan_clk);
        start = 1'b0;
        o_busy1  = busy;
        o_ready1 = word_ready;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) @(negedge scan_clk);
            start = 1'b0; abort = 1'b0; scan_rst = 1'b0;
            if (cyc == post_cyc) o_post = {scan_en, word_ready, busy, done, rb_valid, rb_data};
            if (scan_en === 1'b1) begin
                o_en++;
                if (o_first < 0) o_first = cyc;
                o_last = cyc;
                if (ev) o_en_after_ev++;
            end
            if (rb_valid === 1'b1) begin
                o_rb.push_back(rb_data);
                o_rb_cyc.push_back(cyc);
                if (ev) o_rb_after_ev++;
            end
            if (o_done_cyc >= 0 && busy === 1'b1) o_busy_after_done++;
            if (done === 1'b1) begin
                o_done_n++;
                o_done_cyc  = cyc;
                o_done_busy = busy;
                if (tail < 0) tail = 3;
                if (start_in_done) start = 1'b1;
            end
            if (!ev && abort_at >= 0 && o_en == abort_at) begin
                abort = 1'b1; ev = 1; post_cyc = cyc + 1; tail = 6;
            end
            if (!ev && rst_at >= 0 && o_en == rst_at) begin
                scan_rst = 1'b1; ev = 1; post_cyc = cyc + 1; tail = 6;
            end
            if (!st_done && start_at >= 0 && o_en == start_at) begin
                start = 1'b1; st_done = 1;
            end
            if (ev || idx >= 2) begin
                word_valid = 1'b0;
            end else if (idx == 1 && gap > 0) begin
                word_valid = 1'b0;
                if (word_ready === 1'b1) gap--;
            end else begin
                word_valid = 1'b1;
                word_data  = words[idx];
                if (word_ready === 1'b1) idx++;
            end
            if (tail > 0) tail--;
            if (tail == 0) break;
        end
        word_valid = 1'b0;
        start = 1'b0; abort = 1'b0; scan_rst = 1'b0;
    endtask

    task automatic test_reset();
        scan_rst = 1'b1; start = 1'b0; abort = 1'b0;
        word_valid = 1'b0; word_data = 8'h00; preload_en = 1'b0; preload_val = '0;
        repeat (3) @(negedge scan_clk);
        total_cnt++;
        if ({scan_en, scan_in, word_ready, rb_valid, busy, done, rb_data} !== 14'h0) begin
            bad_cnt++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {scan_en, scan_in, word_ready, rb_valid, busy, done, rb_data});
        end
        scan_rst = 1'b0;
        repeat (2) @(negedge scan_clk);
        total_cnt++;
        if ({scan_en, word_ready, busy, done} !== 4'h0) begin
            bad_cnt++;
            $display("FAIL reset_idle_hold got=%b exp=0", {scan_en, word_ready, busy, done});
        end
    endtask

    task automatic test_basic(input logic [11:0] old, input logic [7:0] w0, input logic [7:0] w1,
                              input int gap);
        load_chain(old);
        run_load(w0, w1, gap, -1, -1, -1, 0);
        total_cnt++;
        if ({o_busy1, o_ready1} !== 2'b11) begin
            bad_cnt++; $display("FAIL start_latency busy/ready got=%b exp=11", {o_busy1, o_ready1});
        end
        total_cnt++;
        if (o_en !== 12) begin
            bad_cnt++; $display("FAIL en_count got=%0d exp=12", o_en);
        end
        total_cnt++;
        if (o_last - o_first + 1 !== 12 + gap) begin
            bad_cnt++; $display("FAIL en_span got=%0d exp=%0d", o_last - o_first + 1, 12 + gap);
        end
        total_cnt++;
        if (chain !== ref_chain(w0, w1)) begin
            bad_cnt++; $display("FAIL chain got=%h exp=%h", chain, ref_chain(w0, w1));
        end
        total_cnt++;
        if (o_done_n !== 1 || o_done_cyc !== o_last + 1 || o_done_busy !== 1'b0) begin
            bad_cnt++;
            $display("FAIL done_timing got n=%0d cyc=%0d busy=%b exp n=1 cyc=%0d busy=0",
                     o_done_n, o_done_cyc, o_done_busy, o_last + 1);
        end
        total_cnt++;
        if (o_rb.size() !== 2) begin
            bad_cnt++; $display("FAIL rb_count got=%0d exp=2", o_rb.size());
        end else begin
            total_cnt++;
            if (o_rb[0] !== ref_rb(old, 0) || o_rb_cyc[0] !== o_first + 8) begin
                bad_cnt++;
                $display("FAIL rb_word0 got=%h@%0d exp=%h@%0d", o_rb[0], o_rb_cyc[0],
                         ref_rb(old, 0), o_first + 8);
            end
            total_cnt++;
            if (o_rb[1] !== ref_rb(old, 1) || o_rb_cyc[1] !== o_done_cyc) begin
                bad_cnt++;
                $display("FAIL rb_word1 got=%h@%0d exp=%h@%0d", o_rb[1], o_rb_cyc[1],
                         ref_rb(old, 1), o_done_cyc);
            end
        end
    endtask

    task automatic test_abort();
        logic [11:0] old, exp_c;
        logic [16:0] s;
        old = 12'($urandom);
        load_chain(old);
        run_load(8'hA5, 8'hC0, 0, 5, -1, -1, 0);
        total_cnt++;
        if (o_post[12:8] !== 5'b0) begin
            bad_cnt++; $display("FAIL abort_next en/ready/busy/done/rbv got=%b exp=00000", o_post[12:8]);
        end
        total_cnt++;
        if (o_en !== 5 || o_done_n !== 0 || o_rb_after_ev !== 0) begin
            bad_cnt++;
            $display("FAIL abort_effect got en=%0d done=%0d rb=%0d exp en=5 done=0 rb=0",
                     o_en, o_done_n, o_rb_after_ev);
        end
        s = {old, 5'b10100};
        exp_c = s[11:0];
        total_cnt++;
        if (chain !== exp_c) begin
            bad_cnt++; $display("FAIL abort_chain got=%h exp=%h", chain, exp_c);
        end
        test_basic(exp_c, 8'h3C, 8'h90, 0);
    endtask

    task automatic test_reset_mid();
        load_chain(12'h000);
        run_load(8'hA5, 8'hC0, 0, -1, 7, -1, 0);
        total_cnt++;
        if (o_post !== 13'h0) begin
            bad_cnt++; $display("FAIL midrst_outputs got=%b exp=0", o_post);
        end
        total_cnt++;
        if (o_en !== 7 || o_done_n !== 0) begin
            bad_cnt++; $display("FAIL midrst_effect got en=%0d done=%0d exp en=7 done=0", o_en, o_done_n);
        end
        test_basic(12'($urandom), 8'hA5, 8'hC0, 0);
    endtask

    task automatic test_ignored_start();
        int sh;
        @(negedge scan_clk);
        start = 1'b1; abort = 1'b1;
        @(negedge scan_clk);
        start = 1'b0; abort = 1'b0;
        sh = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0 || scan_en !== 1'b0 || word_ready !== 1'b0) sh++;
            @(negedge scan_clk);
        end
        total_cnt++;
        if (sh !== 0) begin
            bad_cnt++; $display("FAIL start_abort_idle active_cycles got=%0d exp=0", sh);
        end
        load_chain(12'h5A5);
        run_load(8'h81, 8'h7E, 0, -1, -1, 3, 1);
        total_cnt++;
        if (o_en !== 12 || chain !== ref_chain(8'h81, 8'h7E)) begin
            bad_cnt++;
            $display("FAIL start_while_busy got en=%0d chain=%h exp en=12 chain=%h",
                     o_en, chain, ref_chain(8'h81, 8'h7E));
        end
        total_cnt++;
        if (o_busy_after_done !== 0 || o_done_n !== 1) begin
            bad_cnt++;
            $display("FAIL start_in_done got busy_cycles=%0d done=%0d exp 0 and 1",
                     o_busy_after_done, o_done_n);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            test_basic(12'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 4)));
        end
    endtask

    initial begin
        test_reset();
        test_basic(12'h123, 8'hA5, 8'hC0, 0);
        test_basic(12'h3F0, 8'h00, 8'h00, 0);
        total_cnt++;
        if (chain !== 12'h000) begin
            bad_cnt++; $display("FAIL readback_chain_zero got=%h exp=000", chain);
        end
        test_basic(12'hFFF, 8'hA5, 8'hC0, 3);
        test_abort();
        test_reset_mid();
        test_ignored_start();
        test_random();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scan_cfg_loader.md
# scan_cfg_loader

Sequencer that loads FPGA configuration into the scan chain built from the codebase's `shift_reg` / `shift_reg_1bit` cells.
- Accepts configuration words from a host over a valid/ready stream and serializes them onto `scan_in`, driving `scan_en` for exactly CHAIN_LEN shift cycles.
- Simultaneously captures the chain's previous contents from `scan_out` and returns them as readback words.
- Sits between the configuration host interface and the head/tail of the scan chain.

## Interface
- CHAIN_LEN, 64: total bits in the chain; must be ≥ 1.
- WORD_W, 8: host word width; must be ≥ 2.
- scan_clk  in  1  clock; the same clock that drives the chain cells.
- scan_rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honored only in IDLE.
- abort  in  1  terminates an active load.
- word_data  in  WORD_W  configuration word; MSB is shifted first.
- word_valid  in  1  host has a word on word_data.
- word_ready  out  1  controller accepts word_data this cycle.
- scan_in  out  1  serial data to the chain head (registered).
- scan_en  out  1  chain shift enable (registered).
- scan_out  in  1  serial data from the chain tail (combinational from the last cell).
- rb_data  out  WORD_W  captured readback word.
- rb_valid  out  1  one-cycle strobe qualifying rb_data; there is no backpressure.
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse when a load completes.

## Operation
- States: IDLE, LOAD, DONE.
  - IDLE→LOAD on start & !abort.
  - LOAD→DONE when the CHAIN_LEN-th shift is issued.
  - LOAD→IDLE on abort.
  - DONE→IDLE unconditionally after one cycle.
- Word transfer occurs when word_valid & word_ready. A transfer loads a WORD_W shift buffer and a per-word bit counter.
- word_ready is high in LOAD when both hold:
  - the buffer is empty, or its last bit issues this cycle;
  - at least one chain bit remains beyond the bits already buffered.
- This gives gap-free back-to-back words when word_valid is held high.
- Each cycle in LOAD with a buffered bit: scan_en=1, scan_in=the buffer MSB, then the buffer shifts left and the total counter increments.
- With no buffered bit: scan_en=0 and the chain holds (stall).
- Bit placement: the first bit sent ends in the farthest cell, i.e. the MSB of the last `shift_reg`.
- Partial final word: when CHAIN_LEN mod WORD_W = R ≠ 0, only the upper R bits of the last word are shifted; its low bits are discarded.
- Capture: on every cycle with scan_en=1, the current scan_out bit is shifted into the capture register LSB.
  - After WORD_W captures, rb_data/rb_valid are updated.
  - The final partial capture is left-aligned with zeros in the low bits, and is emitted when the CHAIN_LEN-th bit is captured.
- Counter widths: total counter $clog2(CHAIN_LEN+1); word bit counter $clog2(WORD_W+1). Neither counter wraps; the total counter saturates at CHAIN_LEN and LOAD exits.
- abort: scan_en=0 from the next cycle; the buffer, counters and partial capture are cleared; no done, no further rb_valid; the chain keeps the bits already shifted.
- start while busy or in DONE is ignored. When start and abort arrive together in IDLE, abort wins.

## Timing
- Reset values: scan_en=0, scan_in=0, word_ready=0, rb_data=0, rb_valid=0, busy=0, done=0. State=IDLE; all counters and the buffer are cleared.
- scan_rst mid-load forces these values on the next edge. The chain contents are undefined for the host and must be reloaded.
- start at edge N:
  - busy=1 and word_ready=1 at N+1;
  - a word accepted at edge M gives its first scan_en=1 at M+1.
- A continuous stream gives exactly CHAIN_LEN consecutive scan_en cycles.
- done=1 in the cycle after the last scan_en cycle; busy=0 in that same cycle.
- rb_valid for a word asserts in the cycle after its last capture cycle. The final rb_valid coincides with done.

## Structure
- Shared package/header `scan_cfg_pkg`:
  - state encoding constants IDLE/LOAD/DONE;
  - a function computing R = CHAIN_LEN mod WORD_W and the word count;
  - the counter width constants.
- Sub-module `scan_capture`: WORD_W deserializer with a partial-flush input. It owns rb_data/rb_valid.
- Serializer, counters and FSM stay in the top module.

## Test plan
- CHAIN_LEN=12, WORD_W=8, 12-bit `shift_reg` chain model, words 0xA5 then 0xC0 with word_valid held high → 12 consecutive scan_en cycles, chain=0xA5C, done one cycle later.
- Chain preloaded with 0x3F0, then load 0x00, 0x00 → rb_valid with 0x3F, then with 0x00 coincident with done; chain=0x000.
- word_valid dropped for 3 cycles after the first word → scan_en low for those 3 cycles with no chain change; total scan_en cycles still 12; chain=0xA5C.
- abort after 5 shift cycles → scan_en=0 and busy=0 next cycle, no done, word_ready=0; a subsequent start performs a full 12-bit load.
- scan_rst asserted in the cycle of the 7th shift → all outputs at reset values next cycle; a new load of 0xA5, 0xC0 yields chain=0xA5C.
- start pulsed while busy and start+abort together in IDLE → both ignored: no extra shifts, busy unchanged.
